// File: rtl/data_sram_responder.sv
// data_sram_responder: in-order, fixed-latency SRAM-like data responder over a word-addressed backing array
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    input  logic        stall_in
);
    localparam int PW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int NW = $clog2(MAX_OUT + 1);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    logic              wr_q    [MAX_OUT];
    logic [ADDR_W-1:0] idx_q   [MAX_OUT];
    logic [3:0]        wstrb_q [MAX_OUT];
    logic [31:0]       wdata_q [MAX_OUT];
    logic [CW-1:0]     cnt_q   [MAX_OUT];
    logic [31:0]       mem_q   [2**ADDR_W];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [NW-1:0]     count_q, count_d;
    logic              accept, retire;
    logic [31:0]       word;
    logic              unused_ok;
    assign unused_ok = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
    // occupancy is sampled at the start of the cycle, so a retiring slot is reusable only next cycle
    always_comb begin
        data_sram_addr_ok = resetn && !stall_in && (count_q < NW'(MAX_OUT));
        accept            = data_sram_req && data_sram_addr_ok;
        retire            = resetn && (count_q != '0) && (cnt_q[head_q] == '0);
        data_sram_data_ok = retire;
        word              = mem_q[idx_q[head_q]];
        data_sram_rdata   = (retire && !wr_q[head_q]) ? word : '0;
        head_d            = retire ? ((head_q == PW'(MAX_OUT - 1)) ? '0 : head_q + 1'b1) : head_q;
        tail_d            = accept ? ((tail_q == PW'(MAX_OUT - 1)) ? '0 : tail_q + 1'b1) : tail_q;
        count_d           = count_q + NW'(accept) - NW'(retire);
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUT; i++) begin
            if (!resetn) cnt_q[i] <= '0;
            else if (accept && PW'(i) == tail_q) cnt_q[i] <= CW'(LATENCY - 1);
            else if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q[tail_q]    <= data_sram_wr;
            idx_q[tail_q]   <= data_sram_addr[ADDR_W+1:2];
            wstrb_q[tail_q] <= data_sram_wstrb;
            wdata_q[tail_q] <= data_sram_wdata;
        end
    end
    always_ff @(posedge clk) begin
        if (retire && wr_q[head_q])
            for (int b = 0; b < 4; b++)
                if (wstrb_q[head_q][b]) mem_q[idx_q[head_q]][8*b +: 8] <= wdata_q[head_q][8*b +: 8];
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed scenarios plus randomized traffic against a timestamped queue model
module tb_data_sram_responder;
    logic        clk = 1'b0;
    logic        resetn, req, wr, stall;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok;
    data_sram_responder dut (
        .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
        .data_sram_rdata(rdata), .stall_in(stall)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        wr;
        logic [9:0]  idx;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          due;
    } ent_t;
    ent_t        q[$];
    logic [31:0] mem_m [1024];
    int          cyc = 0, checks = 0, passed = 0;
    logic        exp_aok, exp_dok, obs_aok, obs_dok;
    logic [31:0] exp_rd, obs_rd;
    logic [31:0] addrs [8] = '{32'h40, 32'h80, 32'h0, 32'h4, 32'hFFC, 32'h200, 32'h3FC, 32'h100};
    // one clock cycle: drive, sample at negedge, then advance the model at the edge
    task automatic step(input logic rq, input logic w, input logic [31:0] a, input logic [3:0] st,
                        input logic [31:0] wd, input logic stl, input logic rn, input logic [1:0] sz);
        ent_t e;
        resetn = rn; req = rq; wr = w; addr = a; wstrb = st; wdata = wd; stall = stl; size = sz;
        @(negedge clk);
        exp_aok = rn && !stl && q.size() < 2;
        exp_dok = rn && q.size() > 0 && q[0].due <= cyc;
        exp_rd  = (exp_dok && !q[0].wr) ? mem_m[q[0].idx] : 32'h0;
        obs_aok = addr_ok; obs_dok = data_ok; obs_rd = rdata;
        @(posedge clk);
        if (!rn) q.delete();
        else begin
            if (exp_dok) begin
                if (q[0].wr)
                    for (int b = 0; b < 4; b++)
                        if (q[0].wstrb[b]) mem_m[q[0].idx][8*b +: 8] = q[0].wdata[8*b +: 8];
                void'(q.pop_front());
            end
            if (rq && exp_aok) begin
                e.wr = w; e.idx = a[11:2]; e.wstrb = st; e.wdata = wd; e.due = cyc + 2;
                q.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 2'd2);
    endtask
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0, 2'd2);
            checks++;
            if ({obs_aok, obs_dok} !== 2'b00) $display("FAIL reset_hold k=%0d aok/dok got %b/%b want 0/0", k, obs_aok, obs_dok);
            else passed++;
        end
        idle();
        checks++;
        if (obs_aok !== 1'b1) $display("FAIL reset_release aok got %b want 1", obs_aok); else passed++;
    endtask
    task automatic test_read_after_write();
        step(1'b1, 1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0, 1'b1, 2'd2);
        checks++;
        if (obs_aok !== 1'b1) $display("FAIL raw_accept_wr aok got %b want 1", obs_aok); else passed++;
        step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 2'd2);
        checks++;
        if (obs_aok !== 1'b1) $display("FAIL raw_accept_rd aok got %b want 1", obs_aok); else passed++;
        idle();
        checks++;
        if ({obs_dok, obs_rd} !== {1'b1, 32'h0}) $display("FAIL raw_wr_done dok/rdata got %b/%h want 1/00000000", obs_dok, obs_rd);
        else passed++;
        idle();
        checks++;
        if ({obs_dok, obs_rd} !== {1'b1, 32'h11223344}) $display("FAIL raw_rd_done dok/rdata got %b/%h want 1/11223344", obs_dok, obs_rd);
        else passed++;
        idle();
        checks++;
        if ({obs_dok, obs_rd} !== {1'b0, 32'h0}) $display("FAIL raw_quiet dok/rdata got %b/%h want 0/00000000", obs_dok, obs_rd);
        else passed++;
    endtask
    task automatic test_partial_write();
        step(1'b1, 1'b1, 32'h40, 4'h2, 32'h0000AB00, 1'b0, 1'b1, 2'd0);
        step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 2'd0);
        idle();
        idle();
        checks++;
        if ({obs_dok, obs_rd} !== {1'b1, 32'h1122AB44}) $display("FAIL partial_write dok/rdata got %b/%h want 1/1122ab44", obs_dok, obs_rd);
        else passed++;
        idle();
    endtask
    task automatic test_full_queue();
        logic [5:0] ea, ed;
        ea = 6'b011011;
        ed = 6'b101100;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 2'd2);
            checks++;
            if ({obs_aok, obs_dok, obs_rd} !== {ea[k], ed[k], (ed[k] ? 32'h1122AB44 : 32'h0)})
                $display("FAIL full_queue k=%0d aok/dok/rdata got %b/%b/%h want %b/%b/%h", k, obs_aok, obs_dok, obs_rd,
                         ea[k], ed[k], ed[k] ? 32'h1122AB44 : 32'h0);
            else passed++;
        end
        idle();
        checks++;
        if (obs_dok !== 1'b1) $display("FAIL full_queue_tail dok got %b want 1", obs_dok); else passed++;
        idle();
        checks++;
        if (obs_dok !== 1'b0) $display("FAIL full_queue_empty dok got %b want 0", obs_dok); else passed++;
    endtask
    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 1'b1, 2'd2);
            checks++;
            if ({obs_aok, obs_dok} !== 2'b00) $display("FAIL stall k=%0d aok/dok got %b/%b want 0/0", k, obs_aok, obs_dok);
            else passed++;
        end
        step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 2'd2);
        checks++;
        if (obs_aok !== 1'b1) $display("FAIL stall_release aok got %b want 1", obs_aok); else passed++;
        idle();
        checks++;
        if (obs_dok !== 1'b0) $display("FAIL stall_early dok got %b want 0", obs_dok); else passed++;
        idle();
        checks++;
        if ({obs_dok, obs_rd} !== {1'b1, 32'h1122AB44}) $display("FAIL stall_done dok/rdata got %b/%h want 1/1122ab44", obs_dok, obs_rd);
        else passed++;
    endtask
    task automatic test_reset_mid_flight();
        step(1'b1, 1'b1, 32'h80, 4'hF, 32'h0BADF00D, 1'b0, 1'b1, 2'd2);
        idle();
        idle();
        idle();
        step(1'b1, 1'b1, 32'h80, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b1, 32'h80, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2);
        checks++;
        if (obs_aok !== 1'b1) $display("FAIL midrst_second_accept aok got %b want 1", obs_aok); else passed++;
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 2'd2);
        checks++;
        if (obs_dok !== 1'b0) $display("FAIL midrst_in_reset dok got %b want 0", obs_dok); else passed++;
        for (int k = 0; k < 4; k++) begin
            idle();
            checks++;
            if (obs_dok !== 1'b0) $display("FAIL midrst_after k=%0d dok got %b want 0", k, obs_dok); else passed++;
        end
        step(1'b1, 1'b0, 32'h80, 4'h0, 32'h0, 1'b0, 1'b1, 2'd2);
        idle();
        idle();
        checks++;
        if ({obs_dok, obs_rd} !== {1'b1, 32'h0BADF00D}) $display("FAIL midrst_readback dok/rdata got %b/%h want 1/0badf00d", obs_dok, obs_rd);
        else passed++;
        idle();
    endtask
    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            if (n < 24) begin
                if (n % 3 == 0) step(1'b1, 1'b1, addrs[n/3], 4'hF, $urandom, 1'b0, 1'b1, 2'd2);
                else idle();
            end else if (n < 490) begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     addrs[$urandom_range(0, 7)] | ($urandom & 32'hFFFF_F003), 4'($urandom),
                     $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 49) != 0, 2'($urandom));
            end else idle();
            checks++;
            if ({obs_aok, obs_dok, obs_rd} !== {exp_aok, exp_dok, exp_rd})
                $display("FAIL random n=%0d aok/dok/rdata got %b/%b/%h want %b/%b/%h", n, obs_aok, obs_dok, obs_rd,
                         exp_aok, exp_dok, exp_rd);
            else passed++;
        end
    endtask
    initial begin
        resetn = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0; stall = 1'b0; size = 2'd2;
        @(posedge clk);
        #1;
        test_reset();
        test_read_after_write();
        test_partial_write();
        test_full_queue();
        test_stall();
        test_reset_mid_flight();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
